// File: rtl/gpi_filter_pkg.sv
// rtl/gpi_filter_pkg.sv - shared edge-mode type, parameter defaults and mode decode helpers
package gpi_filter_pkg;

    localparam int NCH_DEFAULT         = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int CNT_W_DEFAULT       = 8;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic rise_enabled(input edge_mode_e mode);
        return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    endfunction

    function automatic logic fall_enabled(input edge_mode_e mode);
        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
    endfunction

endpackage

// File: rtl/gpi_filter_chan.sv
// rtl/gpi_filter_chan.sv - one input channel: synchroniser, debounce counter, edge detect
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   en_i           channel enable; 0 holds all channel state at 0
//   filt_len_i     debounce length in cycles (0 = bypass)
//   mode_i         edge mode for event generation
//   pad_i          raw asynchronous pad data
//   lvl_o          debounced level
//   evt_o          one-cycle event pulse, registered alongside the lvl_o change
module gpi_filter_chan
    import gpi_filter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] filt_len_i,
    input  edge_mode_e       mode_i,
    input  logic             pad_i,
    output logic             lvl_o,
    output logic             evt_o
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   evt_q, evt_d;
    logic                   sync_val;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_i};
        cnt_d  = '0;
        lvl_d  = lvl_q;
        evt_d  = 1'b0;
        if (!en_i) begin
            sync_d = '0;
            lvl_d  = 1'b0;
        end else if (sync_val != lvl_q) begin
            // >= rather than == so a filter length lowered mid-count
            // still releases the level on this comparison.
            if (cnt_q >= filt_len_i) begin
                lvl_d = sync_val;
            end else if (cnt_q == {CNT_W{1'b1}}) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Disabling forces the level low silently, hence the en_i gate.
        if (en_i && (lvl_d != lvl_q)) begin
            evt_d = lvl_d ? rise_enabled(mode_i) : fall_enabled(mode_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            evt_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            evt_q  <= evt_d;
        end
    end

    assign lvl_o = lvl_q;
    assign evt_o = evt_q;

endmodule

// File: rtl/gpi_filter_bank.sv
// rtl/gpi_filter_bank.sv - bank of debounced GPIs with sticky pending bits and masked interrupt
//
// Ports:
//   CLK_I, RST_I   clock, synchronous active-high reset
//   EN_I           per-channel enable, also forwarded as pad input enable
//   STE_CFG_I      Schmitt-trigger select broadcast to every pad
//   FILT_LEN_I     shared debounce length (0 = bypass)
//   MODE_I         2 bits per channel: 00 off, 01 rise, 10 fall, 11 both
//   IRQ_MASK_I     per-channel interrupt enable
//   IRQ_CLR_I      write-1-to-clear of pending bits
//   PAD_DI_I       raw pad data
//   PAD_IE_O       pad input enable (combinational)
//   PAD_STE_O      per-pad Schmitt select (combinational)
//   LVL_O          debounced levels
//   PEND_O         sticky pending bits
//   IRQ_O          OR of pending bits that are unmasked
module gpi_filter_bank
    import gpi_filter_pkg::*;
#(
    parameter int NCH         = NCH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [NCH-1:0]   EN_I,
    input  logic [1:0]       STE_CFG_I,
    input  logic [CNT_W-1:0] FILT_LEN_I,
    input  logic [2*NCH-1:0] MODE_I,
    input  logic [NCH-1:0]   IRQ_MASK_I,
    input  logic [NCH-1:0]   IRQ_CLR_I,
    input  logic [NCH-1:0]   PAD_DI_I,
    output logic [NCH-1:0]   PAD_IE_O,
    output logic [2*NCH-1:0] PAD_STE_O,
    output logic [NCH-1:0]   LVL_O,
    output logic [NCH-1:0]   PEND_O,
    output logic             IRQ_O
);

    logic [NCH-1:0] evt;
    logic [NCH-1:0] pend_q, pend_d;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        gpi_filter_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_chan (
            .clk_i      (CLK_I),
            .rst_i      (RST_I),
            .en_i       (EN_I[g]),
            .filt_len_i (FILT_LEN_I),
            .mode_i     (edge_mode_e'(MODE_I[2*g +: 2])),
            .pad_i      (PAD_DI_I[g]),
            .lvl_o      (LVL_O[g]),
            .evt_o      (evt[g])
        );
    end

    // Clear is applied first so a simultaneous event keeps the bit set.
    always_comb begin
        pend_d = (pend_q & ~IRQ_CLR_I) | evt;
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign PEND_O    = pend_q;
    assign IRQ_O     = |(pend_q & IRQ_MASK_I);
    assign PAD_IE_O  = EN_I;
    assign PAD_STE_O = {NCH{STE_CFG_I}};

endmodule
